// File: rtl/ysyx_22040210_mul_ctrl_if.sv
// EXU request/response and multiplier handshake bundle
// for the MDU multiply sequencer.
interface ysyx_22040210_mul_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        err;
  logic        mul_start;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic        mul_ack;
  logic        mul_busy;
  logic        mul_valid;
  logic [63:0] mul_hi;
  logic [63:0] mul_lo;

  modport master (
    output req_valid, op, src1, src2, flush, resp_ready,
    output mul_busy, mul_valid, mul_hi, mul_lo,
    input  req_ready, resp_valid, resp_data, err,
    input  mul_start, mul_a, mul_b, mul_ack
  );

  modport slave (
    input  req_valid, op, src1, src2, flush, resp_ready,
    input  mul_busy, mul_valid, mul_hi, mul_lo,
    output req_ready, resp_valid, resp_data, err,
    output mul_start, mul_a, mul_b, mul_ack
  );
endinterface

// File: rtl/ysyx_22040210_mul_ctrl.sv
// RV64M multiply sequencer: sign handling around an
// unsigned 64x64 multiplier, one op in flight.
module ysyx_22040210_mul_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  ysyx_22040210_mul_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    DRAIN,
    RESP
  } state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } op_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t      state;
  op_t         op_q;
  op_t         op_d;
  logic        neg_q;
  logic        neg_d;
  logic [7:0]  cnt;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [63:0] a_d;
  logic [63:0] b_d;
  logic [63:0] data_q;
  logic        vld_q;
  logic        sa;
  logic        sb;
  logic        neg_a;
  logic        neg_b;
  logic [127:0] prod;
  logic [127:0] sprod;
  logic [63:0]  res;
  logic        in_wait;
  logic        in_drain;
  logic        wd;
  logic        abort;
  logic        req_rdy;

  always_comb begin
    op_d = OP_MUL;
    unique case (1'b1)
      bus.op == 3'b001: op_d = OP_MULH;
      bus.op == 3'b010: op_d = OP_MULHSU;
      bus.op == 3'b011: op_d = OP_MULHU;
      bus.op == 3'b100: op_d = OP_MULW;
      default:          op_d = OP_MUL;
    endcase
  end

  always_comb begin
    sa    = (op_d == OP_MULH) | (op_d == OP_MULHSU);
    sb    = (op_d == OP_MULH);
    neg_a = sa & bus.src1[63];
    neg_b = sb & bus.src2[63];
    neg_d = neg_a ^ neg_b;
    a_d   = neg_a ? -bus.src1 : bus.src1;
    b_d   = neg_b ? -bus.src2 : bus.src2;
    if (op_d == OP_MULW) begin
      a_d = {32'b0, bus.src1[31:0]};
      b_d = {32'b0, bus.src2[31:0]};
    end
  end

  // Re-apply the sign on the full 128-bit product
  always_comb begin
    prod  = {bus.mul_hi, bus.mul_lo};
    sprod = neg_q ? -prod : prod;
    unique case (op_q)
      OP_MULW:   res = {{32{sprod[31]}}, sprod[31:0]};
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  res = sprod[127:64];
      default:   res = sprod[63:0];
    endcase
  end

  assign in_wait  = (state == WAIT);
  assign in_drain = (state == DRAIN);
  assign wd       = (cnt == TO);
  // A result arriving on the last watchdog cycle still wins
  assign abort    = ((in_wait & ~bus.flush) | in_drain)
                  & ~bus.mul_valid & wd;
  assign req_rdy  = (state == IDLE) & ~bus.flush;

  assign bus.req_ready  = req_rdy;
  assign bus.mul_start  = (state == START) & ~bus.flush
                        & ~bus.mul_busy;
  assign bus.mul_ack    = ((in_wait | in_drain) & bus.mul_valid)
                        | abort;
  assign bus.err        = abort;
  assign bus.mul_a      = a_q;
  assign bus.mul_b      = b_q;
  assign bus.resp_valid = vld_q;
  assign bus.resp_data  = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_q   <= OP_MUL;
      neg_q  <= 1'b0;
      cnt    <= 8'd0;
      a_q    <= 64'd0;
      b_q    <= 64'd0;
      data_q <= 64'd0;
      vld_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid & req_rdy) begin
            a_q   <= a_d;
            b_q   <= b_d;
            neg_q <= neg_d;
            op_q  <= op_d;
            state <= START;
          end
        end
        START: begin
          if (bus.flush) begin
            state <= IDLE;
          end else if (!bus.mul_busy) begin
            cnt   <= 8'd0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mul_valid) begin
            if (bus.flush) begin
              state <= IDLE;
            end else begin
              data_q <= res;
              vld_q  <= 1'b1;
              state  <= RESP;
            end
          end else if (bus.flush) begin
            cnt   <= 8'd0;
            state <= DRAIN;
          end else if (wd) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (bus.mul_valid | wd) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (bus.flush | bus.resp_ready) begin
            vld_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040210_mul_ctrl.sv
// Scoreboard bench for the multiply sequencer with a
// 3-register unsigned multiplier model.
module tb_ysyx_22040210_mul_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22040210_mul_ctrl_if bus ();

  ysyx_22040210_mul_ctrl #(.TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(
    input logic [2:0] o,
    input logic [63:0] a,
    input logic [63:0] b);
    logic [127:0] sa;
    logic [127:0] sb;
    logic [127:0] ua;
    logic [127:0] ub;
    logic [127:0] p;
    logic [31:0]  w;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'b0, a};
    ub = {64'b0, b};
    case (o)
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * ub; return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: begin
        w = a[31:0] * b[31:0];
        return {{32{w[31]}}, w};
      end
      default: begin p = ua * ub; return p[63:0]; end
    endcase
  endfunction

  // Multiplier model: start -> p1 -> p2 -> result reg
  logic         dead = 1'b0;
  logic         force_busy = 1'b0;
  logic         p1v, p2v, rv;
  logic [127:0] p1, p2, rp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1v <= 1'b0; p2v <= 1'b0; rv <= 1'b0;
      p1 <= '0; p2 <= '0; rp <= '0;
    end else begin
      p1v <= bus.mul_start;
      p1  <= {64'b0, bus.mul_a} * {64'b0, bus.mul_b};
      p2v <= p1v;
      p2  <= p1;
      if (p2v && !dead) begin
        rv <= 1'b1;
        rp <= p2;
      end else if (bus.mul_ack) begin
        rv <= 1'b0;
      end
    end
  end

  assign bus.mul_valid = rv;
  assign bus.mul_hi    = rp[127:64];
  assign bus.mul_lo    = rp[63:0];
  assign bus.mul_busy  = p1v | p2v | force_busy;

  // Monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  logic [63:0] last_data = '0;
  int t_acc = 0, t_start = 0, t_ack = 0, t_err = 0, t_rv = 0;
  int n_start = 0, n_ack = 0, n_err = 0, n_resp = 0;
  int n_rise = 0, n_ov = 0;
  logic rv_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.req_valid && bus.req_ready) begin
        t_acc = cyc;
        exp_q.push_back(ref_mul(bus.op, bus.src1, bus.src2));
      end
      if (bus.mul_start) begin t_start = cyc; n_start++; end
      if (bus.mul_ack)   begin t_ack = cyc; n_ack++; end
      if (bus.err)       begin t_err = cyc; n_err++; end
      if (bus.mul_start && bus.mul_ack) n_ov++;
      if (bus.resp_valid && !rv_prev) begin
        t_rv = cyc;
        n_rise++;
      end
      rv_prev = bus.resp_valid;
      if (bus.resp_valid && bus.resp_ready) begin
        n_resp++;
        last_data = bus.resp_data;
        if (exp_q.size() == 0)
          chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        else
          chk("sb_data", bus.resp_data, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] o,
                       input logic [63:0] a,
                       input logic [63:0] b);
    int k = 0;
    bus.req_valid = 1'b1;
    bus.op = o;
    bus.src1 = a;
    bus.src2 = b;
    while (!bus.req_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("req_accept", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n0);
    int k = 0;
    while (n_resp == n0 && k < 60) begin
      @(posedge clk); #1; k++;
    end
    chk("resp_count", 64'(n_resp - n0), 64'd1);
  endtask

  task automatic run(input string tag, input logic [2:0] o,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp);
    int n0 = n_resp;
    issue(o, a, b);
    wait_resp(n0);
    chk(tag, last_data, exp);
  endtask

  initial begin
    int n0, e0, a0, k;
    logic [63:0] r1, r2;
    bus.req_valid  = 1'b0;
    bus.op         = 3'd0;
    bus.src1       = '0;
    bus.src2       = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",   64'(bus.req_ready), 64'd1);
    chk("rst_rv",    64'(bus.resp_valid), 64'd0);
    chk("rst_data",  bus.resp_data, 64'd0);
    chk("rst_start", 64'(bus.mul_start), 64'd0);
    chk("rst_a",     bus.mul_a, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic MUL with latency checks
    run("mul_3x5", 3'd0, 64'd3, 64'd5, 64'd15);
    chk("lat_start", 64'(t_start - t_acc), 64'd1);
    chk("lat_ack",   64'(t_ack - t_acc), 64'd4);
    chk("lat_resp",  64'(t_rv - t_acc), 64'd5);

    run("mulh_m1m1", 3'd1, '1, '1, 64'd0);
    n0 = n_resp;
    issue(3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    chk("mulh_mag_a", bus.mul_a, 64'h8000_0000_0000_0000);
    wait_resp(n0);
    chk("mulh_min", last_data, 64'h4000_0000_0000_0000);
    run("mulhsu", 3'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run("mulhu",  3'd3, '1, 64'd2, 64'd1);
    run("mul_lo", 3'd0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run("op110",  3'd6, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);

    // MULW with two stall cycles on mul_busy
    force_busy = 1'b1;
    n0 = n_resp;
    issue(3'd4, 64'h1234_5678_7FFF_FFFF, 64'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    force_busy = 1'b0;
    wait_resp(n0);
    chk("mulw", last_data, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("stall_lat", 64'(t_start - t_acc), 64'd3);

    // Backpressure: three cycles held off
    bus.resp_ready = 1'b0;
    n0 = n_resp;
    issue(3'd3, '1, '1);
    k = 0;
    while (!bus.resp_valid && k < 60) begin
      @(posedge clk); #1; k++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("bp_data", bus.resp_data, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("bp_rdy",  64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rdy_after", 64'(bus.req_ready), 64'd1);
    chk("bp_hs", 64'(n_resp - n0), 64'd1);

    // Flush during WAIT
    n0 = n_resp;
    e0 = n_rise;
    issue(3'd0, 64'd6, 64'd7);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fl_idle", 64'(bus.req_ready), 64'd1);
    chk("fl_ack",  64'(t_ack - t_acc), 64'd4);
    repeat (5) @(posedge clk);
    #1;
    chk("fl_noresp", 64'(n_rise - e0), 64'd0);
    chk("fl_sb", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) void'(exp_q.pop_back());

    // Watchdog abort
    dead = 1'b1;
    n0 = n_resp;
    e0 = n_err;
    a0 = n_ack;
    issue(3'd0, 64'd1, 64'd1);
    repeat (25) @(posedge clk);
    #1;
    chk("to_err",  64'(n_err - e0), 64'd1);
    chk("to_ack",  64'(n_ack - a0), 64'd1);
    chk("to_lat",  64'(t_err - t_start - 1), 64'd15);
    chk("to_same", 64'(t_ack - t_err), 64'd0);
    chk("to_noresp", 64'(n_resp - n0), 64'd0);
    chk("to_idle", 64'(bus.req_ready), 64'd1);
    if (exp_q.size() > 0) void'(exp_q.pop_back());

    // Asynchronous reset while in WAIT
    issue(3'd1, -64'd5, 64'd3);
    @(posedge clk); #1;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_a",     bus.mul_a, 64'd0);
    chk("ar_b",     bus.mul_b, 64'd0);
    chk("ar_data",  bus.resp_data, 64'd0);
    chk("ar_rv",    64'(bus.resp_valid), 64'd0);
    chk("ar_err",   64'(bus.err), 64'd0);
    chk("ar_start", 64'(bus.mul_start), 64'd0);
    chk("ar_ack",   64'(bus.mul_ack), 64'd0);
    chk("ar_rdy",   64'(bus.req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    dead = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;

    // Random ops, checked through the scoreboard
    for (int i = 0; i < 24; i++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      if (i % 4 == 1) r1[63] = 1'b1;
      if (i % 4 == 2) r2[63] = 1'b1;
      n0 = n_resp;
      issue(3'($urandom_range(0, 7)), r1, r2);
      wait_resp(n0);
    end

    chk("overlap", 64'(n_ov), 64'd0);
    chk("sb_left", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
